rvc_fetch_aligner: RTL and testbench
====================================

Name: rvc_fetch_aligner

Overview:
- Sits between instruction memory and the IF/ID register of the RV32IMC core.
- Extracts the instruction at the current PC, which is halfword aligned, from 32-bit word-aligned fetches. It flags compressed (RVC) instructions for the downstream expander.
- When a 32-bit instruction straddles a word boundary, it issues a second fetch and holds the PC through `stall_compressed_o`, which feeds the pipeline controller's `stall_compressed` input.

Parameters:
- XLEN, 32, address/data width.
- CNT_W, 32, width of the straddle-event performance counter.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- pc_i  in  XLEN  current fetch PC; bit0 is always 0
- fetch_addr_o  out  XLEN  word address to imem; bits [1:0] = 2'b00
- fetch_word_i  in  32  imem read data for fetch_addr_o, combinational same-cycle read
- if_id_en_i  in  1  IF/ID enable from the pipeline controller (if_id_reg_en)
- flush_i  in  1  IF/ID clear / redirect (if_id_reg_clr)
- instr_o  out  32  aligned instruction; RVC occupies [15:0] with [31:16]=0
- instr_valid_o  out  1  instr_o is a real instruction; otherwise instr_o = NOP
- is_compressed_o  out  1  instr_o is a 16-bit RVC encoding
- pc_step_o  out  3  PC increment: 2, 4, or 0 during a stall
- stall_compressed_o  out  1  hold PC for one straddle cycle
- straddle_cnt_o  out  CNT_W  count of straddle events, saturating

Behaviour:
- State register, two states: ALIGNED and SPAN.
- Registers: `hbuf[15:0]` (buffered lower half of a straddling instruction) and `straddle_cnt`.
- Reset: state=ALIGNED, hbuf=0, straddle_cnt=0. Outputs then follow ALIGNED decoding of the current inputs.
- Reset in SPAN aborts the straddle. Nothing is emitted and hbuf is cleared.
- Definitions: low half `L = fetch_word_i[15:0]`, high half `H = fetch_word_i[31:16]`. A half is compressed iff its bits [1:0] != 2'b11.
- ALIGNED: `fetch_addr_o = {pc_i[XLEN-1:2], 2'b00}`.
  - pc_i[1]=0, L compressed: instr_o={16'h0,L}, valid=1, is_compressed=1, step=2.
  - pc_i[1]=0, L not compressed: instr_o=fetch_word_i, valid=1, is_compressed=0, step=4.
  - pc_i[1]=1, H compressed: instr_o={16'h0,H}, valid=1, is_compressed=1, step=2.
  - pc_i[1]=1, H not compressed (straddle): instr_o=NOP (32'h0000_0013), valid=0, step=0, stall_compressed_o=1.
    - On the clock edge with if_id_en_i=1 and flush_i=0: hbuf<=H, state<=SPAN, straddle_cnt increments.
    - If if_id_en_i=0, stay in ALIGNED with nothing latched. The decode repeats next cycle.
- SPAN: `fetch_addr_o = {pc_i[XLEN-1:2]+1, 2'b00}`.
  - The +1 is modulo 2^(XLEN-2): word 0x3FFF_FFFF wraps to 0.
  - instr_o = {fetch_word_i[15:0], hbuf}, valid=1, is_compressed=0, step=4, stall_compressed_o=0.
  - Clock edge with if_id_en_i=1: state<=ALIGNED.
  - if_id_en_i=0: remain in SPAN and hold hbuf. The PC is already held by the controller's other stall terms.
- flush_i=1 has priority over all else:
  - stall_compressed_o=0 and valid=0 combinationally, so the redirect PC can load.
  - Next state is ALIGNED and hbuf is cleared.
- Latency: aligned and RVC instructions take 0 extra cycles. A straddling 32-bit instruction costs exactly 1 bubble cycle.
- pc_i[1] is sampled only in ALIGNED; pc_i must not change while in SPAN.
- straddle_cnt saturates at all-ones and is cleared only by reset.
- The all-zero RVC word (illegal) passes through with is_compressed=1. Illegal-instruction detection is the expander's job.

Decomposition:
- Shared core package:
  - `NOP_INSTR = 32'h0000_0013`
  - `typedef enum logic {ALIGNED, SPAN} align_state_e`
  - `function is_rvc(logic [15:0])`
- No sub-module: a single module with one always_ff block and one always_comb block. RVC expansion stays in the existing decoder path.

Test Plan:
- pc=0x100, word=0x0041_4501 (L=0x4501 RVC) -> instr=0x0000_4501, cmp=1, step=2; then pc=0x102, same word, H=0x0041 RVC -> instr=0x0000_0041, step=2, no stall.
- pc=0x200, word=0x0050_0093 (addi x1,x0,5) -> instr=0x0050_0093, cmp=0, step=4, valid=1, stall=0.
- Straddle: pc=0x302, word@0x300=0x0093_4501, word@0x304=0xABCD_0050.
  - Cycle 0: stall=1, valid=0, instr=NOP, fetch_addr=0x300.
  - Cycle 1: fetch_addr=0x304, instr=0x0050_0093, step=4.
  - straddle_cnt=1.
- Straddle with flush_i=1 asserted in the SPAN cycle -> valid=0, stall=0, next cycle ALIGNED at the redirect pc=0x400 with correct decode; straddle_cnt unchanged from 1.
- Straddle with if_id_en_i=0 for 3 cycles in SPAN -> instr held at 0x0050_0093; exits one cycle after en=1. Reset asserted in SPAN -> ALIGNED, hbuf=0, cnt=0.
- pc=0xFFFF_FFFE with a straddling upper half -> SPAN fetch_addr=0x0000_0000 (wrap); instr assembled from word 0.

Source files
------------

// File: rtl/rvc_fetch_aligner_pkg.sv
// rvc_fetch_aligner_pkg: shared constants, state type and RVC detection for the fetch aligner
package rvc_fetch_aligner_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic {ALIGNED, SPAN} align_state_e;
  function automatic logic is_rvc(input logic [15:0] half);
    return half[1:0] != 2'b11;
  endfunction
endpackage

// File: rtl/rvc_fetch_aligner.sv
// rvc_fetch_aligner: extracts the halfword-aligned instruction at pc_i from word fetches, stalling one cycle on straddles
module rvc_fetch_aligner
  import rvc_fetch_aligner_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  pc_i,
  output logic [XLEN-1:0]  fetch_addr_o,
  input  logic [31:0]      fetch_word_i,
  input  logic             if_id_en_i,
  input  logic             flush_i,
  output logic [31:0]      instr_o,
  output logic             instr_valid_o,
  output logic             is_compressed_o,
  output logic [2:0]       pc_step_o,
  output logic             stall_compressed_o,
  output logic [CNT_W-1:0] straddle_cnt_o
);
  align_state_e     state_q, state_d;
  logic [15:0]      hbuf_q, hbuf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      lo, hi, half;
  logic [XLEN-3:0]  word_nxt;
  logic [31:0]      raw;
  logic             span, straddle, take;
  always_comb begin
    lo       = fetch_word_i[15:0];
    hi       = fetch_word_i[31:16];
    half     = pc_i[1] ? hi : lo;
    span     = state_q == SPAN;
    straddle = !span && pc_i[1] && !is_rvc(hi);
    take     = straddle && if_id_en_i && !flush_i;
    word_nxt = pc_i[XLEN-1:2] + (XLEN-2)'(1);
    fetch_addr_o       = span ? {word_nxt, 2'b00} : {pc_i[XLEN-1:2], 2'b00};
    raw                = span ? {lo, hbuf_q} : is_rvc(half) ? {16'h0, half} : fetch_word_i;
    instr_valid_o      = !flush_i && !straddle && !(span && reset);
    instr_o            = instr_valid_o ? raw : NOP_INSTR;
    is_compressed_o    = !span && !straddle && is_rvc(half);
    pc_step_o          = span ? 3'd4 : straddle ? 3'd0 : is_rvc(half) ? 3'd2 : 3'd4;
    stall_compressed_o = straddle && !flush_i;
    straddle_cnt_o     = cnt_q;
    state_d = flush_i ? ALIGNED : span ? (if_id_en_i ? ALIGNED : SPAN) : (take ? SPAN : ALIGNED);
    hbuf_d  = flush_i ? 16'h0 : take ? hi : hbuf_q;
    cnt_d   = (take && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ALIGNED;
      hbuf_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hbuf_q  <= hbuf_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_rvc_fetch_aligner.sv
// tb_rvc_fetch_aligner: directed plan steps plus a randomized instruction-stream run against a memory-level model
module tb_rvc_fetch_aligner;
  logic        clk = 0, reset = 1, en = 0, flush = 0;
  logic [31:0] pc = 32'h100, fetch_addr, fetch_word, instr, cnt;
  logic        valid, cmp, stall;
  logic [2:0]  step;
  logic [31:0] mem [256];
  int          checks = 0, passes = 0;

  always #5 clk = ~clk;
  assign fetch_word = mem[fetch_addr[9:2]];

  rvc_fetch_aligner #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .pc_i(pc), .fetch_addr_o(fetch_addr), .fetch_word_i(fetch_word),
    .if_id_en_i(en), .flush_i(flush), .instr_o(instr), .instr_valid_o(valid),
    .is_compressed_o(cmp), .pc_step_o(step), .stall_compressed_o(stall), .straddle_cnt_o(cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic set(input logic [31:0] p, input logic e, input logic f, input logic r);
    @(negedge clk);
    pc = p; en = e; flush = f; reset = r;
    #1;
  endtask

  function automatic logic [15:0] half(input logic [31:0] a);
    return a[1] ? mem[a[9:2]][31:16] : mem[a[9:2]][15:0];
  endfunction

  initial begin
    logic [31:0] pc_m, e_instr, e_addr;
    logic [15:0] h0;
    logic        pend, rvc, strad, e_valid, e_stall, e_cmp;
    logic [2:0]  e_step;
    int          cnt_m;
    foreach (mem[i]) mem[i] = 32'h0;
    mem[64]  = 32'h0041_4501;
    mem[128] = 32'h0050_0093;
    mem[192] = 32'h0093_4501;
    mem[193] = 32'hABCD_0050;
    set(32'h100, 1, 0, 0);
    chk("rst_cnt", cnt, 0);
    chk("rvc_lo_instr", instr, 32'h0000_4501);
    chk("rvc_lo_cmp", cmp, 1);
    chk("rvc_lo_step", step, 2);
    chk("rvc_lo_addr", fetch_addr, 32'h100);
    set(32'h102, 1, 0, 0);
    chk("rvc_hi_instr", instr, 32'h0000_0041);
    chk("rvc_hi_step", step, 2);
    chk("rvc_hi_stall", stall, 0);
    set(32'h200, 1, 0, 0);
    chk("full_instr", instr, 32'h0050_0093);
    chk("full_cmp", cmp, 0);
    chk("full_step", step, 4);
    chk("full_valid", valid, 1);
    set(32'h302, 1, 0, 0);
    chk("sp0_stall", stall, 1);
    chk("sp0_valid", valid, 0);
    chk("sp0_instr", instr, 32'h13);
    chk("sp0_addr", fetch_addr, 32'h300);
    chk("sp0_step", step, 0);
    set(32'h302, 1, 0, 0);
    chk("sp1_addr", fetch_addr, 32'h304);
    chk("sp1_instr", instr, 32'h0050_0093);
    chk("sp1_step", step, 4);
    chk("sp1_valid", valid, 1);
    chk("sp1_stall", stall, 0);
    chk("sp1_cnt", cnt, 1);
    set(32'h200, 1, 0, 1);
    mem[0] = 32'h00A0_0513;
    set(32'h302, 1, 0, 0);
    chk("fl0_stall", stall, 1);
    set(32'h302, 1, 1, 0);
    chk("fl_valid", valid, 0);
    chk("fl_stall", stall, 0);
    set(32'h400, 1, 0, 0);
    chk("fl_redir_instr", instr, 32'h00A0_0513);
    chk("fl_redir_valid", valid, 1);
    chk("fl_redir_stall", stall, 0);
    chk("fl_cnt", cnt, 1);
    set(32'h302, 1, 0, 0);
    chk("hold_enter", stall, 1);
    for (int k = 0; k < 3; k++) begin
      set(32'h302, 0, 0, 0);
      chk("hold_instr", instr, 32'h0050_0093);
      chk("hold_addr", fetch_addr, 32'h304);
    end
    set(32'h302, 1, 0, 0);
    chk("hold_last", instr, 32'h0050_0093);
    set(32'h302, 0, 0, 0);
    chk("hold_exit", stall, 1);
    chk("hold_cnt", cnt, 2);
    set(32'h302, 1, 0, 0);
    set(32'h302, 0, 0, 1);
    chk("rst_span_valid", valid, 0);
    set(32'h302, 0, 0, 0);
    chk("rst_span_aligned", stall, 1);
    chk("rst_span_cnt", cnt, 0);
    mem[255] = 32'h0513_4501;
    mem[0]   = 32'h7777_00A0;
    set(32'hFFFF_FFFE, 1, 0, 0);
    chk("wrap0_addr", fetch_addr, 32'hFFFF_FFFC);
    chk("wrap0_stall", stall, 1);
    set(32'hFFFF_FFFE, 1, 0, 0);
    chk("wrap1_addr", fetch_addr, 32'h0);
    chk("wrap1_instr", instr, 32'h00A0_0513);
    foreach (mem[i]) begin
      mem[i] = $urandom;
      if ($urandom_range(0, 1) == 1) mem[i][1:0] = 2'b11;
      if ($urandom_range(0, 1) == 1) mem[i][17:16] = 2'b11;
    end
    set(32'h0, 0, 0, 1);
    pc_m = $urandom & 32'hFFFF_FFFE;
    pend = 0;
    cnt_m = 0;
    for (int i = 0; i < 400; i++) begin
      set(pc_m, $urandom_range(0, 3) != 0, 0, 0);
      h0 = half(pc_m);
      rvc = h0[1:0] != 2'b11;
      strad = !rvc && pc_m[1];
      e_addr = pc_m & 32'hFFFF_FFFC;
      e_instr = rvc ? {16'h0, h0} : {half(pc_m + 2), h0};
      e_valid = 1; e_stall = 0; e_cmp = rvc; e_step = rvc ? 3'd2 : 3'd4;
      if (strad && !pend) begin
        e_instr = 32'h13; e_valid = 0; e_stall = 1; e_step = 0;
      end else if (strad) e_addr = pc_m + 2;
      chk("rnd_instr", instr, e_instr);
      chk("rnd_valid", valid, e_valid);
      chk("rnd_stall", stall, e_stall);
      chk("rnd_step", step, e_step);
      chk("rnd_addr", fetch_addr, e_addr);
      chk("rnd_cnt", cnt, cnt_m);
      if (e_valid) chk("rnd_cmp", cmp, e_cmp);
      if (en) begin
        if (strad && !pend) begin pend = 1; cnt_m++; end
        else begin pend = 0; pc_m = pc_m + {29'h0, e_step}; end
      end
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
